// File: rtl/dmi_responder_if.sv
// DMI request/response handshake bundle.
// Signal names follow the responder's view (_i into it, _o out of it).
interface dmi_responder_if #(
  parameter int ABITS = 7
);
  logic [ABITS+33:0] dmi_req_i;
  logic              dmi_req_valid_i;
  logic              dmi_req_ready_o;
  logic [33:0]       dmi_resp_o;
  logic              dmi_resp_valid_o;
  logic              dmi_resp_ready_i;

  modport master (
    output dmi_req_i,
    output dmi_req_valid_i,
    input  dmi_req_ready_o,
    input  dmi_resp_o,
    input  dmi_resp_valid_o,
    output dmi_resp_ready_i
  );

  modport slave (
    input  dmi_req_i,
    input  dmi_req_valid_i,
    output dmi_req_ready_o,
    output dmi_resp_o,
    output dmi_resp_valid_o,
    input  dmi_resp_ready_i
  );
endinterface

// File: rtl/dmi_responder.sv
// Debug module register responder behind a one-deep DMI response buffer.
// Optional program buffer at 0x20/0x21: define DMI_RESPONDER_PROGBUF_EN.
module dmi_responder #(
  parameter int ABITS = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmi_responder_if.slave   dmi,
  input  logic             halted_i,
  input  logic             cmd_busy_i,
  output logic             dmactive_o,
  output logic             ndmreset_o,
  output logic             haltreq_o,
  output logic             resumereq_o
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  localparam logic [1:0] OP_NOP = 2'd0;
  localparam logic [1:0] OP_RD  = 2'd1;
  localparam logic [1:0] OP_WR  = 2'd2;

  localparam logic [1:0] RSP_OK   = 2'd0;
  localparam logic [1:0] RSP_FAIL = 2'd2;
  localparam logic [1:0] RSP_BUSY = 2'd3;

  localparam logic [ABITS-1:0] A_DATA0 = ABITS'('h04);
  localparam logic [ABITS-1:0] A_DATA1 = ABITS'('h05);
  localparam logic [ABITS-1:0] A_CTL   = ABITS'('h10);
  localparam logic [ABITS-1:0] A_STS   = ABITS'('h11);
  localparam logic [ABITS-1:0] A_PB0   = ABITS'('h20);
  localparam logic [ABITS-1:0] A_PB1   = ABITS'('h21);

  logic [0:0]  state_q, state_d;
  logic [33:0] resp_q, resp_d;
  logic [31:0] data0_q, data0_d;
  logic [31:0] data1_q, data1_d;
  logic [31:0] pb0_q, pb0_d;
  logic [31:0] pb1_q, pb1_d;
  logic        dmact_q, dmact_d;
  logic        ndm_q, ndm_d;
  logic        halt_q, halt_d;
  logic        resume_q, resume_d;

  logic [ABITS-1:0] addr;
  logic [31:0]      wdata;
  logic [1:0]       op;
  logic             accept, drain;
  logic             hit_d0, hit_d1, hit_ctl, hit_sts;
  logic             hit_pb0, hit_pb1, hit_rw;
  logic [31:0]      status, ctl_rd;
  logic [31:0]      rsp_data;
  logic [1:0]       rsp_code;

  assign addr  = dmi.dmi_req_i[ABITS+33:34];
  assign wdata = dmi.dmi_req_i[33:2];
  assign op    = dmi.dmi_req_i[1:0];

  assign dmi.dmi_req_ready_o  = (state_q == EMPTY) | dmi.dmi_resp_ready_i;
  assign dmi.dmi_resp_valid_o = (state_q == FULL);
  assign dmi.dmi_resp_o       = resp_q;

  assign accept = dmi.dmi_req_valid_i & dmi.dmi_req_ready_o;
  assign drain  = dmi.dmi_resp_valid_o & dmi.dmi_resp_ready_i;

  assign hit_d0  = (addr == A_DATA0);
  assign hit_d1  = (addr == A_DATA1);
  assign hit_ctl = (addr == A_CTL);
  assign hit_sts = (addr == A_STS);
`ifdef DMI_RESPONDER_PROGBUF_EN
  assign hit_pb0 = (addr == A_PB0);
  assign hit_pb1 = (addr == A_PB1);
`else
  assign hit_pb0 = 1'b0;
  assign hit_pb1 = 1'b0;
`endif
  assign hit_rw = hit_d0 | hit_d1 | hit_pb0 | hit_pb1;

  assign status = {20'b0, ~halted_i, ~halted_i, halted_i, halted_i,
                   1'b1, 3'b0, 4'd2};
  assign ctl_rd = {halt_q, 29'b0, ndm_q, dmact_q};

  assign dmactive_o  = dmact_q;
  assign ndmreset_o  = ndm_q;
  assign haltreq_o   = halt_q;
  assign resumereq_o = resume_q;

  // Decode the offered request into a response and register updates.
  always_comb begin
    rsp_data = '0;
    rsp_code = RSP_OK;
    data0_d  = data0_q;
    data1_d  = data1_q;
    pb0_d    = pb0_q;
    pb1_d    = pb1_q;
    dmact_d  = dmact_q;
    ndm_d    = ndm_q;
    halt_d   = halt_q;
    resume_d = 1'b0;
    if (op == OP_NOP) begin
      rsp_code = RSP_OK;
    end else if (op == OP_RD) begin
      unique case (1'b1)
        hit_d0:  rsp_data = data0_q;
        hit_d1:  rsp_data = data1_q;
        hit_pb0: rsp_data = pb0_q;
        hit_pb1: rsp_data = pb1_q;
        hit_ctl: rsp_data = ctl_rd;
        hit_sts: rsp_data = status;
        default: rsp_data = '0;
      endcase
      if (hit_rw && cmd_busy_i) rsp_code = RSP_BUSY;
    end else if (op == OP_WR) begin
      if (hit_sts) begin
        rsp_code = RSP_FAIL;
      end else if (hit_ctl) begin
        if (accept) begin
          if (!wdata[0]) begin
            dmact_d = 1'b0;
            ndm_d   = 1'b0;
            halt_d  = 1'b0;
            data0_d = '0;
            data1_d = '0;
            pb0_d   = '0;
            pb1_d   = '0;
          end else begin
            dmact_d  = 1'b1;
            ndm_d    = wdata[1];
            halt_d   = wdata[31];
            resume_d = wdata[30];
          end
        end
      end else if (hit_rw && dmact_q) begin
        if (cmd_busy_i) begin
          rsp_code = RSP_BUSY;
        end else if (accept) begin
          unique case (1'b1)
            hit_d0:  data0_d = wdata;
            hit_d1:  data1_d = wdata;
            hit_pb0: pb0_d   = wdata;
            hit_pb1: pb1_d   = wdata;
            default: ;
          endcase
        end
      end
    end else begin
      rsp_code = RSP_FAIL;
    end
  end

  // Response buffer occupancy and contents.
  always_comb begin
    state_d = state_q;
    resp_d  = resp_q;
    if (accept) begin
      state_d = FULL;
      resp_d  = {rsp_data, rsp_code};
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  // State and register file update; reset drops any held response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= EMPTY;
      resp_q   <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
      pb0_q    <= '0;
      pb1_q    <= '0;
      dmact_q  <= 1'b0;
      ndm_q    <= 1'b0;
      halt_q   <= 1'b0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      resp_q   <= resp_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      pb0_q    <= pb0_d;
      pb1_q    <= pb1_d;
      dmact_q  <= dmact_d;
      ndm_q    <= ndm_d;
      halt_q   <= halt_d;
      resume_q <= resume_d;
    end
  end

endmodule
